// File: rtl/s_term_strobe_pipe_if.sv
// Strobe-path and monitor signal bundle for s_term_strobe_pipe.
// master drives strobes and monitor clear; slave is the repeater tile.
interface s_term_strobe_pipe_if #(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned IDX_W           = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1
);
  logic [MaxFramesPerCol-1:0] FrameStrobe;
  logic [MaxFramesPerCol-1:0] FrameStrobe_O;
  logic                       mon_clr;
  logic [CNT_W-1:0]           strobe_cnt;
  logic [IDX_W-1:0]           last_idx;
  logic                       multi_hot;

  modport master (
    output FrameStrobe,
    output mon_clr,
    input  FrameStrobe_O,
    input  strobe_cnt,
    input  last_idx,
    input  multi_hot
  );

  modport slave (
    input  FrameStrobe,
    input  mon_clr,
    output FrameStrobe_O,
    output strobe_cnt,
    output last_idx,
    output multi_hot
  );
endinterface

// File: rtl/s_term_strobe_pipe.sv
// South-terminal frame-strobe repeater with optional pulse monitor.
// Monitor is built only when S_TERM_STROBE_MON_EN is defined; otherwise its outputs are tied to 0.
module s_term_strobe_pipe #(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned PIPE_STAGES     = 1,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned IDX_W           = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1
) (
  input  logic                 UserCLK,
  input  logic                 reset,
  output logic                 UserCLKo,
  s_term_strobe_pipe_if.slave  bus
);

  // clk_buf: plain pass-through of the user clock.
  assign UserCLKo = UserCLK;

  if (PIPE_STAGES == 0) begin : g_no_pipe
    // my_buf: combinational strobe feed-through.
    assign bus.FrameStrobe_O = bus.FrameStrobe;
  end else begin : g_pipe
    logic [MaxFramesPerCol-1:0] stage_q [PIPE_STAGES];

    always_ff @(posedge UserCLK) begin
      if (reset) begin
        for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
          stage_q[k] <= '0;
        end
      end else begin
        stage_q[0] <= bus.FrameStrobe;
        for (int unsigned k = 1; k < PIPE_STAGES; k++) begin
          stage_q[k] <= stage_q[k-1];
        end
      end
    end

    assign bus.FrameStrobe_O = stage_q[PIPE_STAGES-1];
  end

`ifdef S_TERM_STROBE_MON_EN
  logic [MaxFramesPerCol-1:0] s_q;
  logic [MaxFramesPerCol-1:0] p_q;
  logic [MaxFramesPerCol-1:0] rise;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [IDX_W-1:0]           lo_idx;
  logic                       mh_q, mh_d;

  always_comb begin
    rise   = s_q & ~p_q;
    lo_idx = '0;
    for (int i = int'(MaxFramesPerCol) - 1; i >= 0; i--) begin
      if (rise[i]) begin
        lo_idx = IDX_W'(i);
      end
    end

    cnt_d = cnt_q;
    idx_d = idx_q;
    mh_d  = mh_q;
    // Clear takes priority and drops any same-cycle event; p_q is left alone.
    if (bus.mon_clr) begin
      cnt_d = '0;
      idx_d = '0;
      mh_d  = 1'b0;
    end else begin
      if (|rise) begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        idx_d = lo_idx;
      end
      if ((s_q & (s_q - 1'b1)) != '0) begin
        mh_d = 1'b1;
      end
    end
  end

  always_ff @(posedge UserCLK) begin
    if (reset) begin
      s_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      mh_q  <= 1'b0;
    end else begin
      s_q   <= bus.FrameStrobe;
      p_q   <= s_q;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      mh_q  <= mh_d;
    end
  end

  assign bus.strobe_cnt = cnt_q;
  assign bus.last_idx   = idx_q;
  assign bus.multi_hot  = mh_q;
`else
  logic unused_mon_clr;
  assign unused_mon_clr = bus.mon_clr;

  assign bus.strobe_cnt = '0;
  assign bus.last_idx   = '0;
  assign bus.multi_hot  = 1'b0;
`endif

endmodule

// File: tb/tb_s_term_strobe_pipe.sv
// Self-checking bench: three configurations (2 stages, 0 stages, 1 stage with 4-bit counter)
// driven by one strobe stream and checked against a history-based reference model.
module tb_s_term_strobe_pipe;

`ifdef S_TERM_STROBE_MON_EN
  localparam bit MonEn = 1'b1;
`else
  localparam bit MonEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        mon_clr;
  logic [19:0] fs;
  logic        clko_a, clko_b, clko_c;

  int checks = 0;
  int errors = 0;

  s_term_strobe_pipe_if #(.MaxFramesPerCol(20), .CNT_W(16)) if_a ();
  s_term_strobe_pipe_if #(.MaxFramesPerCol(20), .CNT_W(16)) if_b ();
  s_term_strobe_pipe_if #(.MaxFramesPerCol(20), .CNT_W(4))  if_c ();

  assign if_a.FrameStrobe = fs;
  assign if_b.FrameStrobe = fs;
  assign if_c.FrameStrobe = fs;
  assign if_a.mon_clr     = mon_clr;
  assign if_b.mon_clr     = mon_clr;
  assign if_c.mon_clr     = mon_clr;

  s_term_strobe_pipe #(.MaxFramesPerCol(20), .PIPE_STAGES(2), .CNT_W(16)) dut_a (
    .UserCLK (clk),
    .reset   (rst),
    .UserCLKo(clko_a),
    .bus     (if_a.slave)
  );

  s_term_strobe_pipe #(.MaxFramesPerCol(20), .PIPE_STAGES(0), .CNT_W(16)) dut_b (
    .UserCLK (clk),
    .reset   (rst),
    .UserCLKo(clko_b),
    .bus     (if_b.slave)
  );

  s_term_strobe_pipe #(.MaxFramesPerCol(20), .PIPE_STAGES(1), .CNT_W(4)) dut_c (
    .UserCLK (clk),
    .reset   (rst),
    .UserCLKo(clko_c),
    .bus     (if_c.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: recent effective input samples plus expected monitor state.
  logic [19:0] sv1 = '0;      // input sampled one edge ago (0 after reset)
  logic [19:0] pv1 = '0;      // input sampled two edges ago (0 after reset)
  logic [19:0] pq [4];        // pq[k] = input k edges back, zeroed by reset
  int unsigned cnt16 = 0;
  int unsigned cnt4  = 0;
  logic [4:0]  eidx  = '0;
  logic        emh   = 1'b0;

  task automatic step(input logic [19:0] x, input logic clr, input logic r);
    logic [19:0] rise;
    fs      = x;
    mon_clr = clr;
    rst     = r;
    @(posedge clk);
    rise = sv1 & ~pv1;
    if (r || clr) begin
      cnt16 = 0;
      cnt4  = 0;
      eidx  = '0;
      emh   = 1'b0;
    end else begin
      if (rise != '0) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt4 < 15) cnt4++;
        for (int i = 19; i >= 0; i--) if (rise[i]) eidx = 5'(i);
      end
      if ($countones(sv1) > 1) emh = 1'b1;
    end
    pv1 = r ? 20'd0 : sv1;
    sv1 = r ? 20'd0 : x;
    if (r) begin
      for (int k = 0; k < 4; k++) pq[k] = '0;
    end else begin
      for (int k = 3; k > 0; k--) pq[k] = pq[k-1];
      pq[0] = x;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    step(20'hFFFFF, 1'b0, 1'b1);
    step(20'h00000, 1'b0, 1'b1);
    checks++;
    if (if_a.FrameStrobe_O !== 20'd0) begin
      errors++; $display("FAIL reset_o2 got %h exp 00000", if_a.FrameStrobe_O);
    end
    checks++;
    if (if_c.FrameStrobe_O !== 20'd0) begin
      errors++; $display("FAIL reset_o1 got %h exp 00000", if_c.FrameStrobe_O);
    end
    checks++;
    if (if_a.strobe_cnt !== 16'd0 || if_a.last_idx !== 5'd0 || if_a.multi_hot !== 1'b0) begin
      errors++;
      $display("FAIL reset_mon got cnt=%0d idx=%0d mh=%b exp 0 0 0",
               if_a.strobe_cnt, if_a.last_idx, if_a.multi_hot);
    end
    checks++;
    if (clko_a !== clk || clko_b !== clk || clko_c !== clk) begin
      errors++; $display("FAIL clk_buf got %b%b%b exp %b", clko_a, clko_b, clko_c, clk);
    end
    step(20'h00000, 1'b0, 1'b0);
  endtask

  task automatic test_latency;
    logic [3:0] hi1, hi2;
    hi1 = '0;
    hi2 = '0;
    step(20'd0, 1'b0, 1'b0);
    step(20'd1 << 5, 1'b0, 1'b0);
    checks++;
    if (if_b.FrameStrobe_O !== (20'd1 << 5)) begin
      errors++; $display("FAIL lat_p0 got %h exp %h", if_b.FrameStrobe_O, 20'd1 << 5);
    end
    hi1[0] = if_c.FrameStrobe_O[5];
    hi2[0] = if_a.FrameStrobe_O[5];
    for (int k = 1; k < 4; k++) begin
      step(20'd0, 1'b0, 1'b0);
      hi1[k] = if_c.FrameStrobe_O[5];
      hi2[k] = if_a.FrameStrobe_O[5];
    end
    checks++;
    if (hi2 !== 4'b0010) begin
      errors++; $display("FAIL lat_p2 got %b exp 0010", hi2);
    end
    checks++;
    if (hi1 !== 4'b0001) begin
      errors++; $display("FAIL lat_p1 got %b exp 0001", hi1);
    end
  endtask

  task automatic test_count_hold;
    step(20'd0, 1'b1, 1'b0);
    step(20'd1 << 3, 1'b0, 1'b0);
    step(20'd0, 1'b0, 1'b0);
    step(20'd1 << 7, 1'b0, 1'b0);
    step(20'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(20'd1 << 19, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(20'd0, 1'b0, 1'b0);
    checks++;
    if (if_a.strobe_cnt !== (MonEn ? 16'd3 : 16'd0)) begin
      errors++; $display("FAIL hold_cnt got %0d exp %0d", if_a.strobe_cnt, MonEn ? 3 : 0);
    end
    checks++;
    if (if_a.last_idx !== (MonEn ? 5'd19 : 5'd0) || if_a.multi_hot !== 1'b0) begin
      errors++;
      $display("FAIL hold_idx got idx=%0d mh=%b exp %0d 0", if_a.last_idx, if_a.multi_hot,
               MonEn ? 19 : 0);
    end
  endtask

  task automatic test_multi_hot;
    step(20'h00011, 1'b0, 1'b0);
    step(20'd0, 1'b0, 1'b0);
    step(20'd0, 1'b0, 1'b0);
    checks++;
    if (if_a.multi_hot !== MonEn || if_a.last_idx !== 5'd0) begin
      errors++;
      $display("FAIL mh_set got mh=%b idx=%0d exp %b 0", if_a.multi_hot, if_a.last_idx, MonEn);
    end
    checks++;
    if (if_a.strobe_cnt !== (MonEn ? 16'd4 : 16'd0)) begin
      errors++; $display("FAIL mh_cnt got %0d exp %0d", if_a.strobe_cnt, MonEn ? 4 : 0);
    end
    step(20'd0, 1'b1, 1'b0);
    checks++;
    if (if_a.strobe_cnt !== 16'd0 || if_a.last_idx !== 5'd0 || if_a.multi_hot !== 1'b0) begin
      errors++;
      $display("FAIL mh_clr got cnt=%0d idx=%0d mh=%b exp 0 0 0",
               if_a.strobe_cnt, if_a.last_idx, if_a.multi_hot);
    end
  endtask

  task automatic test_saturation;
    step(20'd0, 1'b1, 1'b0);
    for (int k = 0; k < 17; k++) begin
      step(20'd1 << k, 1'b0, 1'b0);
      step(20'd0, 1'b0, 1'b0);
    end
    checks++;
    if (if_c.strobe_cnt !== (MonEn ? 4'd15 : 4'd0)) begin
      errors++; $display("FAIL sat_cnt4 got %0d exp %0d", if_c.strobe_cnt, MonEn ? 15 : 0);
    end
    checks++;
    if (if_c.last_idx !== (MonEn ? 5'd16 : 5'd0) || if_a.strobe_cnt !== (MonEn ? 16'd17 : 16'd0))
    begin
      errors++;
      $display("FAIL sat_idx got idx=%0d cnt16=%0d exp %0d %0d", if_c.last_idx, if_a.strobe_cnt,
               MonEn ? 16 : 0, MonEn ? 17 : 0);
    end
    // The pulse's event lands on the edge where mon_clr is high.
    step(20'd1 << 9, 1'b0, 1'b0);
    step(20'd0, 1'b1, 1'b0);
    step(20'd0, 1'b0, 1'b0);
    step(20'd0, 1'b0, 1'b0);
    checks++;
    if (if_a.strobe_cnt !== 16'd0 || if_c.strobe_cnt !== 4'd0 || if_a.last_idx !== 5'd0) begin
      errors++;
      $display("FAIL clr_collide got cnt16=%0d cnt4=%0d idx=%0d exp 0 0 0",
               if_a.strobe_cnt, if_c.strobe_cnt, if_a.last_idx);
    end
  endtask

  task automatic test_back_to_back;
    step(20'd0, 1'b1, 1'b0);
    step(20'd1 << 1, 1'b0, 1'b0);
    step(20'd1 << 2, 1'b0, 1'b0);
    step(20'd1 << 3, 1'b0, 1'b0);
    step(20'd0, 1'b0, 1'b0);
    step(20'd0, 1'b0, 1'b0);
    checks++;
    if (if_a.strobe_cnt !== (MonEn ? 16'd3 : 16'd0) || if_a.last_idx !== (MonEn ? 5'd3 : 5'd0))
    begin
      errors++;
      $display("FAIL b2b got cnt=%0d idx=%0d exp %0d %0d", if_a.strobe_cnt, if_a.last_idx,
               MonEn ? 3 : 0, MonEn ? 3 : 0);
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 3; k++) step(20'hFFFFF, 1'b0, 1'b0);
    step(20'hFFFFF, 1'b0, 1'b1);
    checks++;
    if (if_a.FrameStrobe_O !== 20'd0 || if_c.FrameStrobe_O !== 20'd0) begin
      errors++;
      $display("FAIL rstmid_o got o2=%h o1=%h exp 00000 00000", if_a.FrameStrobe_O,
               if_c.FrameStrobe_O);
    end
    step(20'd1 << 2, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(20'd1 << 2, 1'b0, 1'b0);
    checks++;
    if (if_a.strobe_cnt !== (MonEn ? 16'd1 : 16'd0) || if_a.last_idx !== (MonEn ? 5'd2 : 5'd0))
    begin
      errors++;
      $display("FAIL rstmid_cnt got cnt=%0d idx=%0d exp %0d %0d", if_a.strobe_cnt,
               if_a.last_idx, MonEn ? 1 : 0, MonEn ? 2 : 0);
    end
    checks++;
    if (if_a.FrameStrobe_O !== (20'd1 << 2) || if_c.FrameStrobe_O !== (20'd1 << 2)) begin
      errors++;
      $display("FAIL rstmid_refill got o2=%h o1=%h exp 00004", if_a.FrameStrobe_O,
               if_c.FrameStrobe_O);
    end
  endtask

  task automatic test_random;
    logic [19:0] x;
    logic        c, r;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       x = '0;
        1:       x = 20'd1 << $urandom_range(0, 19);
        2:       x = fs;
        default: x = 20'($urandom) & 20'($urandom);
      endcase
      c = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 49) == 0);
      step(x, c, r);
      checks++;
      if (if_a.FrameStrobe_O !== pq[1] || if_c.FrameStrobe_O !== pq[0] ||
          if_b.FrameStrobe_O !== fs) begin
        errors++;
        $display("FAIL rnd_pipe step %0d got %h/%h/%h exp %h/%h/%h", n, if_a.FrameStrobe_O,
                 if_c.FrameStrobe_O, if_b.FrameStrobe_O, pq[1], pq[0], fs);
      end
      checks++;
      if (if_a.strobe_cnt !== (MonEn ? 16'(cnt16) : 16'd0) ||
          if_b.strobe_cnt !== (MonEn ? 16'(cnt16) : 16'd0) ||
          if_c.strobe_cnt !== (MonEn ? 4'(cnt4) : 4'd0)) begin
        errors++;
        $display("FAIL rnd_cnt step %0d got %0d/%0d/%0d exp %0d/%0d", n, if_a.strobe_cnt,
                 if_b.strobe_cnt, if_c.strobe_cnt, MonEn ? cnt16 : 0, MonEn ? cnt4 : 0);
      end
      checks++;
      if (if_a.last_idx !== (MonEn ? eidx : 5'd0) || if_c.last_idx !== (MonEn ? eidx : 5'd0) ||
          if_a.multi_hot !== (MonEn & emh) || if_c.multi_hot !== (MonEn & emh)) begin
        errors++;
        $display("FAIL rnd_mon step %0d got idx=%0d mh=%b exp %0d %b", n, if_a.last_idx,
                 if_a.multi_hot, MonEn ? eidx : 5'd0, MonEn & emh);
      end
    end
  endtask

  initial begin
    fs      = '0;
    mon_clr = 1'b0;
    rst     = 1'b1;
    for (int k = 0; k < 4; k++) pq[k] = '0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_count_hold();
    test_multi_hot();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
